data_mem_access: RTL and testbench
==================================

DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles waited for bus_ack before aborting; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  pipeline presents a memory access this cycle.
REQ-005 memWrite  input  1  access is a store.
REQ-006 memRead  input  1  access is a load (memToReg / writeDataSelection).
REQ-007 dataMemoryType  input  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
REQ-008 addr  input  32  byte address from ALU.
REQ-009 wdata  input  32  store data, value in low bits.
REQ-010 stall  output  1  freeze upstream pipeline.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  formatted load data; valid when done=1.
REQ-013 fault  output  1  with done: access aborted.
REQ-014 fault_cause  output  1  0 misaligned, 1 bus timeout; valid when fault=1.
REQ-015 bus_req / bus_we  output  1 each  bus request and write strobe.
REQ-016 bus_addr  output  32  word address {addr[31:2],2'b00}.
REQ-017 bus_wdata  output  32  lane-replicated store data.
REQ-018 bus_be  output  4  byte enables.
REQ-019 bus_ack  input  1  bus completes request this cycle.
REQ-020 bus_rdata  input  32  read word; valid with bus_ack.

Function
REQ-021 FSM states IDLE, BUS, DONE, FAULT; exactly one active.
REQ-022 IDLE: access accepted when start & (memRead|memWrite); otherwise stay IDLE, stall=0.
REQ-023 On accept: latch address, type, direction, lane data, enables; misaligned (half & addr[0]; word & addr[1:0]!=0) -> FAULT with cause 0; else -> BUS.
REQ-024 stall is combinational: 1 in the IDLE accept cycle and throughout BUS; 0 in IDLE otherwise, and in DONE and FAULT.
REQ-025 BUS: bus_req=1, bus_we/addr/wdata/be held constant from latched values until the bus_ack cycle inclusive.
REQ-026 BUS: bus_ack=1 -> load captures formatted bus_rdata into rdata register, -> DONE; minimum accept-to-done latency 2 cycles (ack in first BUS cycle).
REQ-027 BUS: 8-bit wait counter cleared on entry, +1 per cycle without ack; reaching TIMEOUT_CYCLES -> FAULT with cause 1, bus_req deasserted next cycle; ack in the same cycle as the timeout wins (-> DONE).
REQ-028 DONE: done=1, fault=0, one cycle, -> IDLE; store rdata=0.
REQ-029 FAULT: done=1, fault=1, rdata=0, one cycle, -> IDLE; no bus transaction ever issued for misaligned access.
REQ-030 memRead & memWrite both 1: treated as store.
REQ-031 dataMemoryType 101..111: treated as word.
REQ-032 bus_be: word 1111; half 0011<<(2*addr[1]); byte 0001<<addr[1:0]; reads use the same enables.
REQ-033 bus_wdata: word wdata; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-034 Load format: select lane by addr[1:0]; 000 full word; 001/011 sign-extend from bit 15/7; 010/100 zero-extend.
REQ-035 start while not IDLE ignored; bus_ack outside BUS ignored.
REQ-036 bus_we=0, bus_be=0 whenever bus_req=0.

Reset
REQ-037 rst=1 at an edge: state IDLE, counter 0, all latched fields 0; all outputs 0.
REQ-038 Reset mid-BUS: bus_req 0 from the next cycle, no done pulse; a later bus_ack ignored.
REQ-039 rst has priority over start and bus_ack in the same cycle.

Verification
REQ-040 lb addr=0x103, bus_rdata=0x80_00_00_00, ack after 3 wait cycles -> bus_be=1000, stall 5 cycles, done with rdata=0xFFFFFF80.
REQ-041 sh addr=0x22, wdata=0x1234ABCD, ack first cycle -> bus_addr=0x20, bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, done 2 cycles after accept.
REQ-042 lw addr=0x06 -> no bus_req, next cycle done=1, fault=1, fault_cause=0, rdata=0.
REQ-043 lhu addr=0x00, no ack, TIMEOUT_CYCLES=4 -> bus_req 4 cycles, then done=1, fault=1, fault_cause=1; ack in 4th cycle instead gives normal done.
REQ-044 lw in BUS, rst pulsed for 1 cycle -> bus_req 0 next cycle, all outputs 0, no done; following sb addr=0x1, wdata=0x5A completes with bus_be=0010, bus_wdata=0x5A5A5A5A.

Source files
------------

// File: rtl/data_mem_access_if.sv
// Data memory bus interface.
// Carries the word-addressed request/acknowledge bus between the access unit
// (master) and the memory or bus fabric (slave).
//   bus_req   master->slave  request active; qualifies all other master signals
//   bus_we    master->slave  store when 1, load when 0
//   bus_addr  master->slave  word address, low two bits always 0
//   bus_wdata master->slave  store data replicated across byte lanes
//   bus_be    master->slave  byte enables (also used for loads)
//   bus_ack   slave->master  request completes this cycle
//   bus_rdata slave->master  read word, valid with bus_ack
// Handshake: a request is held unchanged from the first cycle bus_req=1 up to
// and including the cycle in which bus_ack=1; bus_ack while bus_req=0 has no
// effect, and bus_we/bus_be are 0 whenever bus_req=0.
interface data_mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_mem_access.sv
// Data memory access unit.
// Accepts one load/store from the pipeline, checks alignment, issues a single
// word bus request with byte enables, formats the load result and reports
// completion with a one-cycle done pulse (with fault for aborted accesses).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pipeline presents an access this cycle
//   memWrite        access is a store (wins when memRead is also set)
//   memRead         access is a load
//   dataMemoryType  000 word, 001 half, 010 half unsigned, 011 byte,
//                   100 byte unsigned, 101..111 word
//   addr, wdata     byte address and store data (value in low bits)
//   stall           freeze upstream pipeline
//   done            one-cycle completion pulse
//   rdata           formatted load data (0 for stores and faults), with done
//   fault           with done: access aborted
//   fault_cause     0 misaligned, 1 bus timeout; valid with fault
//   dbg_state       current FSM state encoding
//   bus             master side of the data memory bus
module data_mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   memWrite,
  input  logic                   memRead,
  input  logic [2:0]             dataMemoryType,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic                   stall,
  output logic                   done,
  output logic [31:0]            rdata,
  output logic                   fault,
  output logic                   fault_cause,
  output logic [1:0]             dbg_state,
  data_mem_access_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Access size encoding held while the access is in flight.
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // Timeout fires when the counter already holds TIMEOUT_CYCLES-1 and another
  // cycle passes without ack, giving exactly TIMEOUT_CYCLES request cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        cause_q;
  logic [31:0] rdata_q;

  // Decode of the presented access.
  logic        accept;
  logic [1:0]  size_n;
  logic        uns_n;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  always_comb begin
    size_n  = SZ_WORD;
    uns_n   = 1'b0;
    case (dataMemoryType)
      3'b001: size_n = SZ_HALF;
      3'b010: begin size_n = SZ_HALF; uns_n = 1'b1; end
      3'b011: size_n = SZ_BYTE;
      3'b100: begin size_n = SZ_BYTE; uns_n = 1'b1; end
      default: size_n = SZ_WORD;
    endcase

    misaligned = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = wdata;
    case (size_n)
      SZ_HALF: begin
        misaligned = addr[0];
        be_n       = 4'b0011 << {addr[1], 1'b0};
        wdata_n    = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      default: begin
        misaligned = |addr[1:0];
      end
    endcase

    // rst is checked here too so a reset cycle never reports an accept stall.
    accept = !rst && (state == IDLE) && start && (memRead || memWrite);
  end

  // Load formatting: shift the addressed lane down, then extend.
  logic [31:0] lane_word;
  logic [31:0] load_fmt;

  always_comb begin
    lane_word = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_HALF: load_fmt = uns_q ? {16'h0000, lane_word[15:0]}
                                : {{16{lane_word[15]}}, lane_word[15:0]};
      SZ_BYTE: load_fmt = uns_q ? {24'h000000, lane_word[7:0]}
                                : {{24{lane_word[7]}}, lane_word[7:0]};
      default: load_fmt = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      we_q     <= 1'b0;
      size_q   <= SZ_WORD;
      uns_q    <= 1'b0;
      cause_q  <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= addr;
            wdata_q  <= wdata_n;
            be_q     <= be_n;
            we_q     <= memWrite;
            size_q   <= size_n;
            uns_q    <= uns_n;
            wait_cnt <= 8'd0;
            cause_q  <= 1'b0;
            rdata_q  <= 32'd0;
            state    <= misaligned ? FAULT : BUS;
          end
        end
        BUS: begin
          // Ack wins over a timeout reached in the same cycle.
          if (bus.bus_ack) begin
            rdata_q <= we_q ? 32'd0 : load_fmt;
            state   <= DONE;
          end else if (wait_cnt == TO_LAST) begin
            cause_q <= 1'b1;
            state   <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state and latched fields only,
  // except stall, which must also cover the combinational accept cycle.
  always_comb begin
    stall         = accept || (state == BUS);
    done          = (state == DONE) || (state == FAULT);
    fault         = (state == FAULT);
    fault_cause   = (state == FAULT) ? cause_q : 1'b0;
    rdata         = (state == DONE) ? rdata_q : 32'd0;
    dbg_state     = state;
    bus.bus_req   = (state == BUS);
    bus.bus_we    = (state == BUS) ? we_q    : 1'b0;
    bus.bus_addr  = (state == BUS) ? {addr_q[31:2], 2'b00} : 32'd0;
    bus.bus_wdata = (state == BUS) ? wdata_q : 32'd0;
    bus.bus_be    = (state == BUS) ? be_q    : 4'd0;
  end

endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, memWrite, memRead;
  logic [2:0]  dataMemoryType;
  logic [31:0] addr, wdata;
  logic        stall, done, fault, fault_cause;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  data_mem_access_if bus_if ();

  data_mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .memWrite       (memWrite),
    .memRead        (memRead),
    .dataMemoryType (dataMemoryType),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .done           (done),
    .rdata          (rdata),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .dbg_state      (dbg_state),
    .bus            (bus_if.master)
  );

  int checks = 0;
  int errors = 0;
  int stall_cycles;
  int req_cycles;

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; memWrite = 1'b0; memRead = 1'b0;
    dataMemoryType = 3'b000; addr = 32'd0; wdata = 32'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
  endtask

  task automatic present(input logic wr, input logic rd, input logic [2:0] ty,
                         input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; memWrite = wr; memRead = rd;
    dataMemoryType = ty; addr = a; wdata = d;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " fault"}, 32'(fault), 32'd0);
    chk({tag, " cause"}, 32'(fault_cause), 32'd0);
    chk({tag, " rdata"}, rdata, 32'd0);
    chk({tag, " req"}, 32'(bus_if.bus_req), 32'd0);
    chk({tag, " we"}, 32'(bus_if.bus_we), 32'd0);
    chk({tag, " be"}, 32'(bus_if.bus_be), 32'd0);
    chk({tag, " addr"}, bus_if.bus_addr, 32'd0);
    chk({tag, " wdata"}, bus_if.bus_wdata, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk_quiet("reset");
    chk("reset state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // lw addr=0x06: misaligned, no bus request, fault next cycle.
    present(1'b0, 1'b1, 3'b000, 32'h6, 32'h0);
    settle();
    chk("lw_mis accept stall", 32'(stall), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("lw_mis req", 32'(bus_if.bus_req), 32'd0);
    chk("lw_mis done", 32'(done), 32'd1);
    chk("lw_mis fault", 32'(fault), 32'd1);
    chk("lw_mis cause", 32'(fault_cause), 32'd0);
    chk("lw_mis rdata", rdata, 32'd0);
    chk("lw_mis stall", 32'(stall), 32'd0);
    tick();
    chk("lw_mis after done", 32'(done), 32'd0);

    // lh addr=0x01: misaligned half.
    present(1'b0, 1'b1, 3'b001, 32'h1, 32'h0);
    tick();
    idle_inputs();
    settle();
    chk("lh_mis req", 32'(bus_if.bus_req), 32'd0);
    chk("lh_mis fault", 32'(fault), 32'd1);
    chk("lh_mis cause", 32'(fault_cause), 32'd0);
    tick();

    // sh addr=0x22 wdata=0x1234ABCD, ack in first bus cycle.
    present(1'b1, 1'b0, 3'b001, 32'h22, 32'h1234ABCD);
    settle();
    chk("sh accept stall", 32'(stall), 32'd1);
    tick();
    idle_inputs();
    bus_if.bus_ack = 1'b1;
    settle();
    chk("sh req", 32'(bus_if.bus_req), 32'd1);
    chk("sh we", 32'(bus_if.bus_we), 32'd1);
    chk("sh addr", bus_if.bus_addr, 32'h20);
    chk("sh be", 32'(bus_if.bus_be), 32'hC);
    chk("sh wdata", bus_if.bus_wdata, 32'hABCDABCD);
    chk("sh stall", 32'(stall), 32'd1);
    tick();
    bus_if.bus_ack = 1'b0;
    settle();
    chk("sh done", 32'(done), 32'd1);
    chk("sh fault", 32'(fault), 32'd0);
    chk("sh rdata", rdata, 32'd0);
    chk("sh req off", 32'(bus_if.bus_req), 32'd0);
    chk("sh be off", 32'(bus_if.bus_be), 32'd0);
    chk("sh we off", 32'(bus_if.bus_we), 32'd0);
    tick();

    // lb addr=0x103, three wait cycles then ack with 0x80000000.
    stall_cycles = 0;
    present(1'b0, 1'b1, 3'b011, 32'h103, 32'h0);
    settle();
    if (stall) stall_cycles++;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_inputs();
      if (i == 3) begin
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 32'h80000000;
      end
      settle();
      if (stall) stall_cycles++;
      chk("lb req", 32'(bus_if.bus_req), 32'd1);
      chk("lb be", 32'(bus_if.bus_be), 32'h8);
      chk("lb addr", bus_if.bus_addr, 32'h100);
      chk("lb we", 32'(bus_if.bus_we), 32'd0);
    end
    tick();
    idle_inputs();
    settle();
    if (stall) stall_cycles++;
    chk("lb done", 32'(done), 32'd1);
    chk("lb fault", 32'(fault), 32'd0);
    chk("lb rdata", rdata, 32'hFFFFFF80);
    chk("lb stall cycles", 32'(stall_cycles), 32'd5);
    tick();

    // lhu addr=0x00, no ack: timeout after 4 request cycles.
    req_cycles = 0;
    present(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      settle();
      if (bus_if.bus_req) req_cycles++;
      tick();
    end
    chk("lhu_to req cycles", 32'(req_cycles), 32'd4);
    chk("lhu_to req off", 32'(bus_if.bus_req), 32'd0);
    chk("lhu_to done", 32'(done), 32'd1);
    chk("lhu_to fault", 32'(fault), 32'd1);
    chk("lhu_to cause", 32'(fault_cause), 32'd1);
    chk("lhu_to rdata", rdata, 32'd0);
    tick();
    chk("lhu_to after", 32'(done), 32'd0);

    // lhu addr=0x00 with ack in the 4th (timeout) cycle: ack wins.
    present(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'h12348001;
    settle();
    chk("lhu_ack req", 32'(bus_if.bus_req), 32'd1);
    chk("lhu_ack be", 32'(bus_if.bus_be), 32'h3);
    tick();
    idle_inputs();
    settle();
    chk("lhu_ack done", 32'(done), 32'd1);
    chk("lhu_ack fault", 32'(fault), 32'd0);
    chk("lhu_ack rdata", rdata, 32'h00008001);
    tick();

    // lh addr=0x02 sign-extends upper half.
    present(1'b0, 1'b1, 3'b001, 32'h2, 32'h0);
    tick();
    idle_inputs();
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'h80017FFF;
    settle();
    chk("lh be", 32'(bus_if.bus_be), 32'hC);
    tick();
    idle_inputs();
    settle();
    chk("lh rdata", rdata, 32'hFFFF8001);
    tick();

    // memRead & memWrite with type 101: store word.
    present(1'b1, 1'b1, 3'b101, 32'h10, 32'hCAFEF00D);
    tick();
    idle_inputs();
    bus_if.bus_ack = 1'b1;
    settle();
    chk("rw we", 32'(bus_if.bus_we), 32'd1);
    chk("rw be", 32'(bus_if.bus_be), 32'hF);
    chk("rw wdata", bus_if.bus_wdata, 32'hCAFEF00D);
    chk("rw addr", bus_if.bus_addr, 32'h10);
    tick();
    idle_inputs();
    settle();
    chk("rw done", 32'(done), 32'd1);
    chk("rw rdata", rdata, 32'd0);
    tick();

    // lw addr=0x8, reset pulsed mid-BUS, later ack ignored.
    present(1'b0, 1'b1, 3'b000, 32'h8, 32'h0);
    tick();
    idle_inputs();
    settle();
    chk("lw_rst req", 32'(bus_if.bus_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk_quiet("lw_rst after");
    chk("lw_rst state", 32'(dbg_state), 32'd0);
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'hDEADBEEF;
    tick();
    bus_if.bus_ack = 1'b0;
    settle();
    chk("lw_rst late ack done", 32'(done), 32'd0);
    chk("lw_rst late ack req", 32'(bus_if.bus_req), 32'd0);

    // sb addr=0x1 wdata=0x5A after the reset.
    present(1'b1, 1'b0, 3'b011, 32'h1, 32'h5A);
    tick();
    idle_inputs();
    bus_if.bus_ack = 1'b1;
    settle();
    chk("sb be", 32'(bus_if.bus_be), 32'h2);
    chk("sb wdata", bus_if.bus_wdata, 32'h5A5A5A5A);
    chk("sb we", 32'(bus_if.bus_we), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("sb done", 32'(done), 32'd1);
    chk("sb fault", 32'(fault), 32'd0);
    tick();
    chk("sb idle", 32'(dbg_state), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
